// File: rtl/serial_pattern_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_RPT_W      = 4;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register; exposes the MSB and the bit below it
// so the caller can form the next MSB ahead of the clock edge.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb,
  output logic             o_msb_sub
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb     = r_q[WIDTH-1];
  assign o_msb_sub = r_q[WIDTH-2];

endmodule

// File: rtl/serial_pattern_gen.sv
// MSB-first serial word transmitter with programmable repeat count and a
// fixed idle gap between repeats; every output is a flop.
//
//   state    | meaning
//   ST_IDLE  | waiting for a load, load_ready high
//   ST_SHIFT | driving one word bit per cycle
//   ST_GAP   | idle-zero cycles between repeated words
module serial_pattern_gen
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int RPT_W      = DEF_RPT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W      = $clog2(WIDTH);
  localparam int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LOAD_I);

  state_t r_state, w_state_n;

  logic [WIDTH-1:0] r_word;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [RPT_W-1:0] r_rpt_left;

  logic r_out, r_out_valid, r_busy, r_done, r_load_ready;
  logic w_out_n, w_out_valid_n, w_busy_n, w_done_n, w_load_ready_n;

  logic             w_accept, w_last_bit, w_more, w_gap_end, w_reload;
  logic             w_pload, w_pshift, w_msb, w_msb_sub, w_msb_n;
  logic [WIDTH-1:0] w_ldata;

  assign w_accept   = (r_state == ST_IDLE) & load_valid;
  assign w_last_bit = (r_state == ST_SHIFT) & (r_bit_cnt == BIT_LAST);
  assign w_more     = (r_rpt_left > RPT_W'(1));
  assign w_gap_end  = (r_gap_cnt == '0);
  assign w_reload   = w_last_bit & w_more;

  // Repeats come from the captured copy so the live input may change freely.
  assign w_ldata  = (r_state == ST_IDLE) ? pattern : r_word;
  assign w_pload  = w_accept | w_reload;
  assign w_pshift = (r_state == ST_SHIFT) & ~w_pload;
  assign w_msb_n  = w_pload ? w_ldata[WIDTH-1] : (w_pshift ? w_msb_sub : w_msb);

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_pload),
    .i_shift  (w_pshift),
    .i_data   (w_ldata),
    .o_msb    (w_msb),
    .o_msb_sub(w_msb_sub)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_out        <= w_out_n;
      r_out_valid  <= w_out_valid_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
      r_load_ready <= w_load_ready_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          if (!w_more)              w_state_n = ST_IDLE;
          else if (GAP_CYCLES == 0) w_state_n = ST_SHIFT;
          else                      w_state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_end) w_state_n = ST_SHIFT;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid_n  = (w_state_n == ST_SHIFT);
    w_out_n        = w_out_valid_n & w_msb_n;
    w_busy_n       = (w_state_n != ST_IDLE);
    w_done_n       = w_last_bit & ~w_more;
    w_load_ready_n = (w_state_n == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word     <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_rpt_left <= '0;
    end else begin
      if (w_accept) begin
        r_word     <= pattern;
        r_bit_cnt  <= '0;
        r_rpt_left <= (repeat_cnt == '0) ? RPT_W'(1) : repeat_cnt;
      end else if (r_state == ST_SHIFT) begin
        if (w_last_bit) begin
          r_bit_cnt <= '0;
          if (w_more) r_rpt_left <= r_rpt_left - RPT_W'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end

      // Gap timer counts down to zero; terminal count releases the next word.
      if (w_reload && (GAP_CYCLES > 0)) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == ST_GAP) && !w_gap_end) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

endmodule
